// File: rtl/acc_pkg.sv
// acc_pkg: shared types and float constants for the window accumulator path.
// Holds the controller state encoding and float32 literals.
package acc_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    DRAIN     = 2'd1,
    CAPTURE   = 2'd2,
    FLUSH_CLR = 2'd3
  } acc_state_e;

endpackage

// File: rtl/acc_window_ctrl.sv
// acc_window_ctrl: feeds products to the float32 accumulator, counts windows,
// waits out accumulator latency and hands each window sum downstream.
module acc_window_ctrl
  import acc_pkg::*;
#(
  parameter int N_TERMS = 9,
  parameter int ACC_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [FP_W-1:0]  acc_op_b,
  output logic             acc_en,
  output logic             acc_clr,
  input  logic [FP_W-1:0]  acc_sum,
  output logic [FP_W-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] win_count
);

  localparam int WAIT_W    = $clog2(ACC_LAT + 1);
  localparam int DRAIN_END = (ACC_LAT > 1) ? ACC_LAT - 2 : 0;

  localparam logic [CNT_W-1:0]  LAST_T = CNT_W'(N_TERMS - 1);
  localparam logic [WAIT_W-1:0] W_END  = WAIT_W'(DRAIN_END);

  acc_state_e r_state;
  acc_state_e w_state_nxt;

  logic [CNT_W-1:0]  r_term_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic [FP_W-1:0]   r_out_data;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_win_count;

  logic w_last;
  logic w_in_ready;
  logic w_accept;
  logic w_flush_hit;

  assign w_last      = (r_term_cnt == LAST_T);
  assign w_flush_hit = (r_state == ACCUM) & flush;

  // Last term waits while the previous sum is unread, so CAPTURE never
  // overwrites a pending result.
  assign w_in_ready = (r_state == ACCUM) & ~flush &
                      (~w_last | ~r_out_valid);
  assign w_accept   = in_valid & w_in_ready;

  assign in_ready  = w_in_ready;
  assign acc_en    = w_accept;
  assign acc_op_b  = in_data;
  assign acc_clr   = (r_state == CAPTURE) | (r_state == FLUSH_CLR);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign win_count = r_win_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACCUM: begin
        if (flush) begin
          w_state_nxt = FLUSH_CLR;
        end else if (w_accept && w_last) begin
          w_state_nxt = (ACC_LAT > 1) ? DRAIN : CAPTURE;
        end
      end
      DRAIN: begin
        if (r_wait == W_END) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_state_nxt = ACCUM;
      end
      FLUSH_CLR: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_term_cnt <= '0;
    end else if (w_flush_hit) begin
      r_term_cnt <= '0;
    end else if (w_accept) begin
      r_term_cnt <= w_last ? '0 : r_term_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (r_state == DRAIN) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= FP_ZERO;
      r_out_valid <= 1'b0;
      r_win_count <= '0;
    end else if (r_state == CAPTURE) begin
      r_out_data  <= acc_sum;
      r_out_valid <= 1'b1;
      r_win_count <= r_win_count + 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_window_ctrl.sv
// tb_acc_window_ctrl: three controller configs paired with a float32
// accumulator model, checked against a window-level reference.
module tb_acc_window_ctrl;

  localparam int N_A = 9;

  localparam logic [31:0] F_ZERO = 32'h0000_0000;
  localparam logic [31:0] F_HALF = 32'h3F00_0000;
  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_1P5  = 32'h3FC0_0000;
  localparam logic [31:0] F_TWO  = 32'h4000_0000;

  logic clk;
  logic rst;

  int n_chk;
  int n_err;

  // instance A: N=9, LAT=1, CNT_W=16
  logic [31:0] a_in_data, a_acc_op_b, a_acc_sum, a_out_data;
  logic        a_in_valid, a_in_ready, a_flush, a_acc_en, a_acc_clr;
  logic        a_out_valid, a_out_ready;
  logic [15:0] a_win_count;

  // instance B: N=4, LAT=3, CNT_W=2
  logic [31:0] b_in_data, b_acc_op_b, b_acc_sum, b_out_data;
  logic        b_in_valid, b_in_ready, b_flush, b_acc_en, b_acc_clr;
  logic        b_out_valid, b_out_ready;
  logic [1:0]  b_win_count;

  // instance C: N=1, LAT=1, CNT_W=16
  logic [31:0] c_in_data, c_acc_op_b, c_acc_sum, c_out_data;
  logic        c_in_valid, c_in_ready, c_flush, c_acc_en, c_acc_clr;
  logic        c_out_valid, c_out_ready;
  logic [15:0] c_win_count;

  acc_window_ctrl #(.N_TERMS(9), .ACC_LAT(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .flush(a_flush),
    .acc_op_b(a_acc_op_b), .acc_en(a_acc_en), .acc_clr(a_acc_clr),
    .acc_sum(a_acc_sum),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .win_count(a_win_count)
  );

  acc_window_ctrl #(.N_TERMS(4), .ACC_LAT(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush(b_flush),
    .acc_op_b(b_acc_op_b), .acc_en(b_acc_en), .acc_clr(b_acc_clr),
    .acc_sum(b_acc_sum),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .win_count(b_win_count)
  );

  acc_window_ctrl #(.N_TERMS(1), .ACC_LAT(1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst),
    .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .flush(c_flush),
    .acc_op_b(c_acc_op_b), .acc_en(c_acc_en), .acc_clr(c_acc_clr),
    .acc_sum(c_acc_sum),
    .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .win_count(c_win_count)
  );

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 4);
    case (k)
      0:       return F_ZERO;
      1:       return F_HALF;
      2:       return F_ONE;
      3:       return F_1P5;
      default: return F_TWO;
    endcase
  endfunction

  // accumulators: A and C read the sum register, B sees it 3 cycles late
  logic [31:0] a_sum_r, c_sum_r, b_sum_r, b_d1, b_d2;

  always @(posedge clk or posedge rst) begin
    if (rst) a_sum_r <= 32'h0;
    else if (a_acc_clr) a_sum_r <= 32'h0;
    else if (a_acc_en) a_sum_r <= r2f(f2r(a_sum_r) + f2r(a_acc_op_b));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) c_sum_r <= 32'h0;
    else if (c_acc_clr) c_sum_r <= 32'h0;
    else if (c_acc_en) c_sum_r <= r2f(f2r(c_sum_r) + f2r(c_acc_op_b));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_sum_r <= 32'h0;
      b_d1    <= 32'h0;
      b_d2    <= 32'h0;
    end else begin
      if (b_acc_clr) b_sum_r <= 32'h0;
      else if (b_acc_en) b_sum_r <= r2f(f2r(b_sum_r) + f2r(b_acc_op_b));
      b_d1 <= b_sum_r;
      b_d2 <= b_d1;
    end
  end

  assign a_acc_sum = a_sum_r;
  assign b_acc_sum = b_d2;
  assign c_acc_sum = c_sum_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // window-level reference for instance A
  int          m_cnt, m_busy, m_wins, m_nacc;
  bit          m_clr, m_pend;
  logic [31:0] m_data;
  real         m_sum;
  int          n_en, n_clr, n_ov;

  task automatic model_reset();
    m_cnt = 0; m_busy = 0; m_wins = 0; m_nacc = 0;
    m_clr = 0; m_pend = 0; m_data = 32'h0; m_sum = 0.0;
    n_en = 0; n_clr = 0; n_ov = 0;
  endtask

  task automatic cyc_a(input logic v, input logic [31:0] d,
                       input logic f, input logic ordy);
    bit e_rdy, e_en, e_clr;
    a_in_valid = v; a_in_data = d; a_flush = f; a_out_ready = ordy;
    @(negedge clk);
    e_rdy = (m_busy == 0) && !m_clr && !f &&
            !((m_cnt == N_A - 1) && m_pend);
    e_en  = v && e_rdy;
    e_clr = m_clr || (m_busy == 1);
    chk("a_in_ready", 32'(a_in_ready), 32'(e_rdy));
    chk("a_acc_en", 32'(a_acc_en), 32'(e_en));
    chk("a_acc_clr", 32'(a_acc_clr), 32'(e_clr));
    chk("a_out_valid", 32'(a_out_valid), 32'(m_pend));
    chk("a_out_data", a_out_data, m_data);
    chk("a_win_count", 32'(a_win_count), 32'(m_wins & 32'hFFFF));
    if (v) chk("a_op_b", a_acc_op_b, d);
    if (a_acc_en) n_en++;
    if (a_acc_clr) n_clr++;
    if (a_out_valid) n_ov++;
    if (m_pend && ordy) m_pend = 0;
    if (m_busy > 0) begin
      if (m_busy == 1) begin
        m_pend = 1;
        m_data = r2f(m_sum);
        m_wins++;
        m_sum = 0.0;
      end
      m_busy--;
    end else if (m_clr) begin
      m_clr = 0;
    end else if (f) begin
      m_clr = 1;
      m_cnt = 0;
      m_sum = 0.0;
    end else if (e_en) begin
      m_nacc++;
      m_sum = m_sum + f2r(d);
      if (m_cnt == N_A - 1) begin
        m_cnt = 0;
        m_busy = 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    a_in_valid = 0; a_flush = 0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_win_count", 32'(a_win_count), 32'h0);
    chk("rst_acc_clr", 32'(a_acc_clr), 32'h0);
    chk("rst_in_ready", 32'(a_in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    real bsum;
    logic [31:0] d;
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    a_in_data = 0; a_in_valid = 0; a_flush = 0; a_out_ready = 0;
    b_in_data = 0; b_in_valid = 0; b_flush = 0; b_out_ready = 1;
    c_in_data = 0; c_in_valid = 0; c_flush = 0; c_out_ready = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset_all();

    // nine 1.0 terms, result read immediately
    for (int i = 0; i < 13; i++) cyc_a(i < 9, F_ONE, 1'b0, 1'b1);
    chk("t1_sum", a_out_data, 32'h4110_0000);
    chk("t1_win", 32'(a_win_count), 32'd1);
    chk("t1_n_en", 32'(n_en), 32'd9);
    chk("t1_n_clr", 32'(n_clr), 32'd1);
    chk("t1_n_ov", 32'(n_ov), 32'd1);

    // back-to-back windows with the first result held
    reset_all();
    for (int i = 0; i < 60; i++)
      cyc_a(m_nacc < 18, (m_nacc < 9) ? F_ONE : F_TWO, 1'b0, i >= 20);
    chk("t2_nacc", 32'(m_nacc), 32'd18);
    chk("t2_sum", a_out_data, 32'h4190_0000);
    chk("t2_win", 32'(a_win_count), 32'd2);

    // flush after four terms, then nine 0.5 terms
    reset_all();
    for (int i = 0; i < 20; i++)
      cyc_a(m_nacc < 13, (m_nacc < 4) ? F_ONE : F_HALF, i == 4, 1'b1);
    chk("t3_sum", a_out_data, 32'h4090_0000);
    chk("t3_win", 32'(a_win_count), 32'd1);
    chk("t3_n_clr", 32'(n_clr), 32'd2);

    // reset in the middle of a window
    reset_all();
    for (int i = 0; i < 5; i++) cyc_a(1'b1, F_ONE, 1'b0, 1'b1);
    reset_all();
    for (int i = 0; i < 12; i++) cyc_a(i < 9, F_ONE, 1'b0, 1'b1);
    chk("t5_sum", a_out_data, 32'h4110_0000);
    chk("t5_win", 32'(a_win_count), 32'd1);

    // random traffic against the reference
    reset_all();
    for (int i = 0; i < 800; i++)
      cyc_a($urandom_range(0, 3) != 0, pick(),
            $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);

    // B: three-cycle accumulator latency and 2-bit window counter
    for (int w = 0; w < 5; w++) begin
      bsum = 0.0;
      for (int k = 0; k < 4; k++) begin
        d = pick();
        b_in_valid = 1; b_in_data = d;
        @(negedge clk);
        chk("b_rdy_acc", 32'(b_in_ready), 32'h1);
        chk("b_clr_acc", 32'(b_acc_clr), 32'h0);
        bsum = bsum + f2r(d);
        @(posedge clk);
        #1;
      end
      for (int k = 1; k <= 3; k++) begin
        b_in_valid = 1; b_in_data = F_ONE;
        @(negedge clk);
        chk("b_rdy_wait", 32'(b_in_ready), 32'h0);
        chk("b_clr_wait", 32'(b_acc_clr), 32'(k == 3));
        @(posedge clk);
        #1;
      end
      b_in_valid = 0;
      @(negedge clk);
      chk("b_out_valid", 32'(b_out_valid), 32'h1);
      chk("b_out_data", b_out_data, r2f(bsum));
      chk("b_win", 32'(b_win_count), 32'((w + 1) % 4));
      @(posedge clk);
      #1;
    end

    // C: single-term windows
    c_in_valid = 1; c_in_data = F_TWO; c_out_ready = 0;
    @(negedge clk);
    chk("c_rdy0", 32'(c_in_ready), 32'h1);
    @(posedge clk);
    #1;
    c_in_valid = 0;
    @(negedge clk);
    chk("c_clr1", 32'(c_acc_clr), 32'h1);
    chk("c_rdy1", 32'(c_in_ready), 32'h0);
    @(posedge clk);
    #1;
    c_in_valid = 1; c_in_data = F_HALF; c_out_ready = 1;
    @(negedge clk);
    chk("c_ov2", 32'(c_out_valid), 32'h1);
    chk("c_data2", c_out_data, F_TWO);
    chk("c_rdy2_held", 32'(c_in_ready), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("c_ov3", 32'(c_out_valid), 32'h0);
    chk("c_rdy3", 32'(c_in_ready), 32'h1);
    @(posedge clk);
    #1;
    c_in_valid = 0;
    @(negedge clk);
    chk("c_clr4", 32'(c_acc_clr), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("c_data5", c_out_data, F_HALF);
    chk("c_win5", 32'(c_win_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
